// File: rtl/truth_table_sweeper.sv
`default_nettype none
// ============================================================================
//  Module      : truth_table_sweeper
//  Description : Exhaustive truth-table sequencer for a 1-output combinational
//                DUT. Drives vectors 0..2^N_IN-1 in ascending order and holds
//                each one for SETTLE+1 cycles. At the end of each window it
//                samples dut_out and compares it with EXPECTED[vector]. It
//                reports pass/fail, the first failing index, the mismatch
//                count and every captured response.
//  Ports       : clk, rst_n      - clock (rising edge), async active-low reset
//                start           - begin a sweep (only honoured in IDLE)
//                abort           - synchronous abort, highest priority
//                dut_in[N_IN]    - vector driven to the DUT
//                dut_out         - DUT response
//                busy            - sweep in progress
//                done            - one-cycle pulse at sweep completion
//                pass            - last completed sweep had no mismatches
//                fail_cnt[N_IN+1]- mismatch count of current/last sweep
//                fail_idx[N_IN]  - first mismatching vector (fail_cnt != 0)
//                captured[2^N_IN]- captured DUT response per vector
//  Options     : TTS_STOP_ON_FAIL_EN - when defined, the first mismatch ends
//                the sweep immediately (done, pass=0, fail_cnt=1).
//  Revision    : 1.0 - initial release
// ============================================================================
module truth_table_sweeper #(
    parameter int                  N_IN     = 4,
    parameter int                  SETTLE   = 2,
    parameter logic [2**N_IN-1:0]  EXPECTED = 16'h6996
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    output logic [N_IN-1:0]     dut_in,
    input  logic                dut_out,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [N_IN:0]       fail_cnt,
    output logic [N_IN-1:0]     fail_idx,
    output logic [2**N_IN-1:0]  captured
);

    localparam int              c_CW     = $clog2(SETTLE + 1);
    localparam logic [c_CW-1:0] c_SETTLE = c_CW'(SETTLE);
    localparam logic [N_IN-1:0] c_LAST   = {N_IN{1'b1}};

`ifdef TTS_STOP_ON_FAIL_EN
    localparam logic            c_STOP_ON_FAIL = 1'b1;
`else
    localparam logic            c_STOP_ON_FAIL = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_SAMPLE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [N_IN-1:0]      r_idx;
    logic [c_CW-1:0]      r_cnt;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_pass;
    logic [N_IN:0]        r_fail_cnt;
    logic [N_IN-1:0]      r_fail_idx;
    logic [2**N_IN-1:0]   r_captured;

    logic                 w_mis;
    logic                 w_end_sweep;

    // The vector index doubles as the DUT drive: it is only changed at the
    // start of a window, so dut_in is stable for the whole SETTLE+1 cycles.
    assign dut_in   = r_idx;
    assign busy     = r_busy;
    assign done     = r_done;
    assign pass     = r_pass;
    assign fail_cnt = r_fail_cnt;
    assign fail_idx = r_fail_idx;
    assign captured = r_captured;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_mis       = (dut_out != EXPECTED[r_idx]);
        w_end_sweep = (r_idx == c_LAST) || (c_STOP_ON_FAIL && w_mis);

        if (abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   if (start) w_state_nxt = S_WAIT;
                // The counter is loaded with SETTLE, so reaching 1 marks the
                // SETTLE-th edge spent in WAIT.
                S_WAIT:   if (r_cnt == c_CW'(1)) w_state_nxt = S_SAMPLE;
                S_SAMPLE: w_state_nxt = w_end_sweep ? S_IDLE : S_WAIT;
                default:  w_state_nxt = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx      <= '0;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_fail_cnt <= '0;
            r_fail_idx <= '0;
            r_captured <= '0;
        end else begin
            r_done <= 1'b0;
            if (abort) begin
                // Partial results (count, first index, captures) are kept
                // for inspection; only a running sweep loses its pass flag.
                r_idx  <= '0;
                r_cnt  <= '0;
                r_busy <= 1'b0;
                if (r_state != S_IDLE) r_pass <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_idx      <= '0;
                            r_cnt      <= c_SETTLE;
                            r_busy     <= 1'b1;
                            r_pass     <= 1'b0;
                            r_fail_cnt <= '0;
                            r_fail_idx <= '0;
                            r_captured <= '0;
                        end
                    end
                    S_WAIT: begin
                        r_cnt <= r_cnt - c_CW'(1);
                    end
                    S_SAMPLE: begin
                        r_captured[r_idx] <= dut_out;
                        if (w_mis) begin
                            r_fail_cnt <= r_fail_cnt + (N_IN+1)'(1);
                            if (r_fail_cnt == '0) r_fail_idx <= r_idx;
                        end
                        if (w_end_sweep) begin
                            // Final verdict must include the sample taken now.
                            r_busy <= 1'b0;
                            r_done <= 1'b1;
                            r_pass <= (r_fail_cnt == '0) && !w_mis;
                        end else begin
                            r_idx <= r_idx + N_IN'(1);
                            r_cnt <= c_SETTLE;
                        end
                    end
                    default: begin
                        r_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
Hardware sequencer that exhaustively sweeps the N_IN-bit input vector of a combinational DUT, for example the 4-input simtest gate.
- Drives vectors 0..2^N_IN-1 in ascending order.
- Waits a settle interval after each vector, then samples the 1-bit DUT output.
- Compares each sample against a parameterised expected truth table.
- Reports pass/fail, the first failing index and the mismatch count.

This replaces the hand-written stepping bench with a reusable on-chip self-check.

Parameters:
N_IN, 4, DUT input width; 1..8
SETTLE, 2, cycles each vector is held before sampling; minimum 1, 0 is illegal
EXPECTED, 16'h6996, expected truth table, width 2^N_IN; bit i = expected dut_out for vector i

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin sweep; sampled only in IDLE
abort  in  1  synchronous abort; takes priority over all sweep activity
dut_in  out  N_IN  vector driven to the DUT
dut_out  in  1  DUT response
busy  out  1  high while a sweep is running
done  out  1  one-cycle pulse when a sweep completes
pass  out  1  1 = last completed sweep had no mismatches
fail_cnt  out  N_IN+1  number of mismatches in the current/last sweep
fail_idx  out  N_IN  index of the first mismatch; valid when fail_cnt != 0
captured  out  2^N_IN  captured DUT response per vector

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, and all of the following are 0:
  - dut_in, busy, done, pass, fail_cnt, fail_idx, captured
  - internal idx and settle counter
- States: IDLE, WAIT, SAMPLE.
- IDLE with start=1 at edge e0:
  - idx<=0, dut_in<=0, busy<=1
  - fail_cnt, fail_idx, captured and pass cleared
  - settle counter loaded with SETTLE; go to WAIT.
- WAIT: counter decrements each edge; after exactly SETTLE edges in WAIT, go to SAMPLE.
- SAMPLE, on its edge:
  - captured[idx]<=dut_out.
  - On mismatch with EXPECTED[idx]: fail_cnt++; if fail_cnt was 0, fail_idx<=idx.
  - If idx != 2^N_IN-1: idx++, dut_in<=idx+1, reload counter, go to WAIT.
  - If idx is last: go to IDLE; busy<=0; done<=1 for one cycle; pass<=(final fail_cnt==0). The final count includes the current sample.
- Timing:
  - Each vector occupies SETTLE+1 cycles.
  - Sample edge for vector i is edge (i+1)*(SETTLE+1) after e0.
  - The done edge is 2^N_IN*(SETTLE+1) after e0; 48 with defaults.
- dut_out is sampled at the SAMPLE edge, i.e. the value present during the preceding cycle. dut_in is stable for the whole SETTLE+1 window.
- After done, dut_in holds the last vector until the next start, abort or reset.
- fail_cnt cannot overflow: width N_IN+1 holds up to 2^N_IN.
- start while busy is ignored. start and done in the same cycle: start is not seen until IDLE, i.e. the next cycle.
- abort=1 in any state, at the edge:
  - state IDLE; busy<=0; dut_in<=0; no done pulse.
  - pass<=0; fail_cnt, fail_idx and captured are left as partial results.
  - abort in IDLE has no effect other than dut_in<=0.
  - abort with start in the same cycle: abort wins.
- Reset mid-sweep: immediate return to reset values; no done pulse.

Optional Feature:
Macro: TTS_STOP_ON_FAIL_EN.
- Defined: the first mismatch in SAMPLE ends the sweep at that edge.
  - Go to IDLE, busy<=0, done<=1, pass<=0, fail_cnt=1.
  - captured bits for later vectors stay 0; dut_in holds the failing vector.
- Undefined: the full sweep always runs, as described above.

Test Plan:
All scenarios use default parameters unless stated.
- DUT modelled as a..d XOR; start pulse at e0 -> done at edge 48, pass=1, fail_cnt=0, captured=16'h6996, dut_in=4'hF afterwards.
- DUT stuck-at-0 -> done at edge 48, pass=0, fail_cnt=8, fail_idx=1, captured=16'h0000.
- XOR DUT with vector 9 inverted -> fail_cnt=1, fail_idx=9, captured=16'h6B96, pass=0.
- abort at edge 20 of a sweep -> busy=0 and dut_in=0 after that edge, no done, pass=0. A new start then completes normally at +48 with pass=1. A start pulse mid-sweep changes nothing.
- rst_n dropped asynchronously at edge 30 -> all outputs 0 immediately without a clock edge; no done; a subsequent start runs a full 48-cycle sweep.
- TTS_STOP_ON_FAIL_EN defined, stuck-at-0 DUT -> done at edge 6, fail_idx=1, fail_cnt=1, dut_in=1, captured=16'h0000.
